// File: rtl/wave_sched_pkg.sv
// Shared encodings for the sample scheduler, waveform memory and menu controller.
package wave_sched_pkg;

    localparam int unsigned MODE_W     = 2;
    localparam int unsigned UNDERRUN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        MODE_SINE     = 2'd0,
        MODE_SQUARE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_SAWTOOTH = 2'd3
    } mode_e;

endpackage

// File: rtl/wave_sched_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled, one-cycle tick on the last count.
module wave_sched_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wave_sched.sv
// DDS sample scheduler: paces waveform-memory addresses at a fixed sample rate and
// applies waveform-mode changes only at phase wrap.
module wave_sched
    import wave_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 500,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FTW_MIN    = 1,
    parameter int unsigned FTW_MAX    = 1 << (PHASE_W - 1),
    parameter int unsigned FTW_STEP   = 256,
    parameter int unsigned FTW_INIT   = 65536
) (
    input  logic                  clk,
    input  logic                  aaa,
    input  logic                  run,
    input  logic [MODE_W-1:0]     mode_req,
    input  logic                  mode_set,
    input  logic                  freq_up,
    input  logic                  freq_dn,
    input  logic                  dac_ready,
    output logic [ADDR_W-1:0]     addr,
    output logic [MODE_W-1:0]     memmode,
    output logic                  sample_stb,
    output logic [PHASE_W-1:0]    ftw,
    output logic [UNDERRUN_W-1:0] underrun,
    output logic [1:0]            state
);

    localparam int unsigned EXT_W = PHASE_W + 1;

    state_e                  state_q;
    mode_e                   memmode_q;
    mode_e                   pend_q;
    logic [PHASE_W-1:0]      phase_q;
    logic [PHASE_W-1:0]      ftw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    stb_q;
    logic [UNDERRUN_W-1:0]   under_q;

    logic [PHASE_W:0]        phase_sum_d;
    logic [PHASE_W:0]        ftw_up_d;
    logic [PHASE_W-1:0]      ftw_d;
    logic                    active;
    logic                    tick;

    assign active = (state_q != ST_IDLE);

    wave_sched_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (aaa),
        .en_i  (active),
        .clr_i (!active || !run),
        .tick_o(tick)
    );

    // Phase sum keeps the carry bit for wrap detection; tuning word saturates at both ends.
    always_comb begin
        phase_sum_d = {1'b0, phase_q} + {1'b0, ftw_q};
        ftw_up_d    = {1'b0, ftw_q} + EXT_W'(FTW_STEP);
        ftw_d       = ftw_q;
        if (freq_up && !freq_dn) begin
            ftw_d = (ftw_up_d > EXT_W'(FTW_MAX)) ? PHASE_W'(FTW_MAX) : ftw_up_d[PHASE_W-1:0];
        end else if (freq_dn && !freq_up) begin
            ftw_d = ({1'b0, ftw_q} < EXT_W'(FTW_MIN) + EXT_W'(FTW_STEP)) ?
                    PHASE_W'(FTW_MIN) : ftw_q - PHASE_W'(FTW_STEP);
        end
    end

    always_ff @(posedge clk or posedge aaa) begin
        if (aaa) begin
            state_q   <= ST_IDLE;
            memmode_q <= MODE_SINE;
            pend_q    <= MODE_SINE;
            phase_q   <= '0;
            ftw_q     <= PHASE_W'(FTW_INIT);
            addr_q    <= '0;
            stb_q     <= 1'b0;
            under_q   <= '0;
        end else begin
            ftw_q <= ftw_d;
            stb_q <= 1'b0;
            if (state_q == ST_IDLE && mode_set) begin
                memmode_q <= mode_e'(mode_req);
            end
            if (!run) begin
                state_q <= ST_IDLE;
                phase_q <= '0;
                addr_q  <= '0;
            end else if (state_q == ST_IDLE) begin
                state_q <= ST_RUN;
                phase_q <= '0;
            end else begin
                if (tick) begin
                    phase_q <= phase_sum_d[PHASE_W-1:0];
                    if (dac_ready) begin
                        addr_q <= phase_sum_d[PHASE_W-1 -: ADDR_W];
                        stb_q  <= 1'b1;
                    end else if (under_q != {UNDERRUN_W{1'b1}}) begin
                        under_q <= under_q + UNDERRUN_W'(1);
                    end
                    // Pending mode lands on the wrap tick, whether or not the DAC takes it.
                    if (state_q == ST_SWITCH && phase_sum_d[PHASE_W]) begin
                        memmode_q <= pend_q;
                        state_q   <= ST_RUN;
                    end
                end
                if (mode_set) begin
                    pend_q  <= mode_e'(mode_req);
                    state_q <= ST_SWITCH;
                end
            end
        end
    end

    assign addr       = addr_q;
    assign memmode    = memmode_q;
    assign sample_stb = stb_q;
    assign ftw        = ftw_q;
    assign underrun   = under_q;
    assign state      = state_q;

endmodule

// File: doc/wave_sched.md
# wave_sched

Sample scheduler for the signal generator: a DDS-style phase accumulator that paces waveform-memory reads at a fixed sample rate. It hands each new sample address to the DAC path only when the DAC controller is idle, and applies waveform-mode changes only at phase wrap. It sits between the key/menu controller (frequency and mode requests) and the waveform memory/DAC controller pair, replacing free-running memory clocking with one registered address strobe per sample.

## Interface
- SAMPLE_DIV, 500 — clk cycles per sample tick (50 MHz / 500 = 100 kS/s); ≥ 2
- PHASE_W, 24 — phase accumulator / tuning-word width
- ADDR_W, 8 — waveform memory address width; ≤ PHASE_W
- FTW_MIN, 1 — lowest tuning word
- FTW_MAX, 2^(PHASE_W-1) — highest tuning word (Nyquist)
- FTW_STEP, 256 — tuning-word increment per frequency key pulse
- FTW_INIT, 65536 — tuning word after reset
- clk  in  1  master clock, 50 MHz
- aaa  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = generate samples
- mode_req  in  2  requested waveform mode
- mode_set  in  1  one-cycle pulse; latch mode_req as pending
- freq_up  in  1  one-cycle pulse; ftw += FTW_STEP
- freq_dn  in  1  one-cycle pulse; ftw -= FTW_STEP
- dac_ready  in  1  DAC controller idle, can accept a sample
- addr  out  ADDR_W  waveform memory address
- memmode  out  2  active waveform mode to memory
- sample_stb  out  1  one-cycle pulse; addr/memmode valid, DAC may load
- ftw  out  PHASE_W  current tuning word (for display)
- underrun  out  8  saturating count of ticks dropped on !dac_ready
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 SWITCH

## Operation
- Reset values: phase=0, addr=0, memmode=0, sample_stb=0, ftw=FTW_INIT, underrun=0, state=IDLE, tick counter=0, pending flag clear.
- Tick counter counts 0..SAMPLE_DIV-1 and only while state≠IDLE. A tick is asserted on the cycle the count equals SAMPLE_DIV-1. The counter clears on entry to RUN.
- IDLE: phase is held at 0 and there are no strobes. A mode_set here writes memmode directly on the next cycle. When run=1, go to RUN.
- RUN: on a tick, phase_n = phase + ftw (mod 2^PHASE_W). Phase always advances.
  - If dac_ready=1: addr <= phase_n[PHASE_W-1 -: ADDR_W] and sample_stb=1.
  - If dac_ready=0: no strobe, addr is held, underrun += 1 (saturating at 255).
- mode_set while in RUN or SWITCH: mode_req is latched as pending (a later pulse overwrites it). State goes to SWITCH.
- SWITCH: behaves like RUN, with one extra rule. On the first tick whose add carries out of PHASE_W (wrap), memmode <= pending on the same edge as addr/sample_stb. The pending flag clears and the state returns to RUN.
  - If that wrap tick is dropped for !dac_ready, memmode still switches.
- run=0 in any state: on the next edge go to IDLE, clear phase, addr and the tick counter, and drop the pending flag with no apply. An in-flight strobe is not generated.
- freq_up/freq_dn: applied on the next edge and clamped to [FTW_MIN, FTW_MAX]. Both pulses in the same cycle: ignored. A change in the same cycle as a tick takes effect on the following tick.
- underrun clears only on reset.

## Timing
- All outputs are registered; sample_stb is high for exactly one clk.
- The first strobe occurs SAMPLE_DIV cycles after the edge that enters RUN. After that, strobes are SAMPLE_DIV cycles apart when dac_ready stays 1.
- addr and memmode change only on strobe edges (or a dropped wrap tick, or in IDLE) and hold between them.
- Output frequency = (CLK/SAMPLE_DIV)·ftw/2^PHASE_W. There is no phase discontinuity on an ftw change.
- Reset asserted mid-operation forces reset values asynchronously. Release is synchronous to clk.

## Structure
- Shared package holds the FSM state encoding (IDLE/RUN/SWITCH) and the waveform mode constants (0 sine, 1 square, 2 triangle, 3 sawtooth), so the memory block and the menu controller use the same values.
- One natural sub-module: `tick_gen`, a parameterised SAMPLE_DIV counter with enable and synchronous clear, outputting the one-cycle tick.
- The phase accumulator, FTW clamp logic and FSM stay in wave_sched.

## Test plan
All scenarios use SAMPLE_DIV=4, PHASE_W=24, ADDR_W=8, FTW_INIT=0x010000.
- Reset then run=1, dac_ready=1 → first sample_stb 4 cycles after RUN entry, then addr = 1, 2, 3 … with strobes every 4 cycles; ftw=0x010000.
- ftw=0x7F0000, run for 3 strobes → addr = 0x7F, 0xFE, 0x7D (wrap). Then freq_up ×300 → ftw clamps at 0x800000.
- mode_req=2 with a mode_set pulse mid-cycle → state=SWITCH, memmode stays 0 until the strobe with the wrapped address (0x00 at FTW 0x010000), then memmode=2 and state=RUN.
- dac_ready=0 for 3 ticks → no strobes, underrun=3. Next strobe addr reflects 4 phase advances (e.g. 1 → 5).
- freq_up and freq_dn asserted in the same cycle → ftw unchanged. freq_dn from FTW_MIN → ftw stays 1.
- run=0 while a mode switch is pending, then run=1 → state IDLE→RUN, phase and addr restart at 0, memmode unchanged. Asserting aaa mid-run gives all reset values immediately.
